// File: rtl/serial_addsub8_if.sv
// Request/result bundle for the group-serial 8-bit adder/subtractor.
// The master drives the operands and START; the slave returns status and results.
interface serial_addsub8_if;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] s;
    logic       cout;
    logic       g;
    logic       p;
    logic       ovf;

    modport master (
        output start, sub, a, b, cin,
        input  busy, done, s, cout, g, p, ovf
    );

    modport slave (
        input  start, sub, a, b, cin,
        output busy, done, s, cout, g, p, ovf
    );
endinterface

// File: rtl/serial_addsub8.sv
// 8-bit add/subtract that handles one 2-bit group per cycle.
// The carry between groups is kept in a register. Subtraction adds the inverted B.
//
// state | meaning
// IDLE  | waiting for START; results from the last operation are held
// RUN   | processing group idx_q, one group per cycle
// FIN   | results valid, DONE pulses; START is accepted here as well
module serial_addsub8 (
    input  logic             clk,
    input  logic             rst,
    serial_addsub8_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] s_q, s_d;
    logic [1:0] idx_q, idx_d;
    logic       carry_q, carry_d;
    logic       cout_q, cout_d;
    logic       g_q, g_d;
    logic       p_q, p_d;
    logic       ovf_q, ovf_d;

    logic [1:0] ga, gb, gsum;
    logic       c_mid, c_out;
    logic [8:0] gen_sum;

    // Datapath for the current group. b_q already holds the effective B.
    always_comb begin
        ga      = a_q[{idx_q, 1'b0} +: 2];
        gb      = b_q[{idx_q, 1'b0} +: 2];
        c_mid   = (ga[0] & gb[0]) | ((ga[0] ^ gb[0]) & carry_q);
        gsum    = {ga[1] ^ gb[1] ^ c_mid, ga[0] ^ gb[0] ^ carry_q};
        c_out   = (ga[1] & gb[1])
                | ((ga[1] ^ gb[1]) & (ga[0] & gb[0]))
                | ((ga[1] ^ gb[1]) & (ga[0] ^ gb[0]) & carry_q);
        gen_sum = {1'b0, a_q} + {1'b0, b_q};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        g_d     = g_q;
        p_d     = p_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, FIN: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b ^ {8{bus.sub}};
                    carry_d = bus.cin ^ bus.sub;
                    idx_d   = 2'd0;
                    s_d     = 8'h00;
                    cout_d  = 1'b0;
                    g_d     = 1'b0;
                    p_d     = 1'b0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                s_d[{idx_q, 1'b0} +: 2] = gsum;
                carry_d = c_out;
                idx_d   = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    // Group 3 closes the operation: c_mid is the carry into bit 7.
                    state_d = FIN;
                    cout_d  = c_out;
                    ovf_d   = c_mid ^ c_out;
                    g_d     = gen_sum[8];
                    p_d     = &(a_q ^ b_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            s_q     <= 8'h00;
            idx_q   <= 2'd0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            g_q     <= 1'b0;
            p_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            g_q     <= g_d;
            p_q     <= p_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == FIN);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
    assign bus.g    = g_q;
    assign bus.p    = p_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_addsub8.sv
// Bench for serial_addsub8: directed corner cases and random operations.
// Expected results come from plain integer arithmetic.
module tb_serial_addsub8;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_addsub8_if bus ();

    serial_addsub8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout obs=running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0] s;
        logic       cout;
        logic       g;
        logic       p;
        logic       ovf;
    } res_t;

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        int   ua, ub, sa, sb, ci, ur, sr, beff;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = int'(cin);
        if (sub) begin
            ur     = ua - ub - ci;
            sr     = sa - sb - ci;
            r.cout = (ur >= 0);
            beff   = 255 - ub;
        end else begin
            ur     = ua + ub + ci;
            sr     = sa + sb + ci;
            r.cout = (ur > 255);
            beff   = ub;
        end
        r.s   = 8'((ur % 256 + 256) % 256);
        r.ovf = (sr > 127) || (sr < -128);
        r.g   = (ua + beff) > 255;
        r.p   = ((ua ^ beff) == 255);
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge of the DONE cycle.
    task automatic op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input bit poke_run);
        res_t e;
        e = model(a, b, cin, sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        bus.sub   = sub;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.cin   = 1'($urandom);
        bus.sub   = 1'($urandom);
        check("s_cleared", 32'(bus.s), 32'h0);
        check("busy_first", 32'(bus.busy), 32'h1);
        check("done_first", 32'(bus.done), 32'h0);
        if (poke_run) begin
            bus.start = 1'b1;
            bus.a     = ~a;
            bus.b     = b + 8'h5a;
        end
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            check("busy_run", 32'(bus.busy), 32'h1);
            check("done_run", 32'(bus.done), 32'h0);
        end
        @(negedge clk);
        check("done_fin", 32'(bus.done), 32'h1);
        check("busy_fin", 32'(bus.busy), 32'h0);
        check("s", 32'(bus.s), 32'(e.s));
        check("cout", 32'(bus.cout), 32'(e.cout));
        check("g", 32'(bus.g), 32'(e.g));
        check("p", 32'(bus.p), 32'(e.p));
        check("ovf", 32'(bus.ovf), 32'(e.ovf));
    endtask

    // One idle cycle after DONE: pulse ends, results stay put.
    task automatic check_hold(input logic [7:0] a, input logic [7:0] b,
                              input logic cin, input logic sub);
        res_t e;
        e = model(a, b, cin, sub);
        bus.start = 1'b0;
        @(negedge clk);
        check("done_drop", 32'(bus.done), 32'h0);
        check("busy_idle", 32'(bus.busy), 32'h0);
        check("s_hold", 32'(bus.s), 32'(e.s));
        check("flags_hold", 32'({bus.cout, bus.g, bus.p, bus.ovf}),
              32'({e.cout, e.g, e.p, e.ovf}));
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs;
        total     = 0;
        bad       = 0;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        rst       = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        check("rst_s", 32'(bus.s), 32'h0);
        check("rst_flags", 32'({bus.cout, bus.g, bus.p, bus.ovf}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op(8'h3c, 8'h25, 1'b0, 1'b0, 1'b0);
        check_hold(8'h3c, 8'h25, 1'b0, 1'b0);
        op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        check_hold(8'h10, 8'h01, 1'b0, 1'b1);
        op(8'h7f, 8'h01, 1'b0, 1'b0, 1'b0);
        op(8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
        op(8'hff, 8'h00, 1'b1, 1'b0, 1'b0);
        check_hold(8'hff, 8'h00, 1'b1, 1'b0);

        // START during RUN must be ignored.
        op(8'h5a, 8'h33, 1'b1, 1'b0, 1'b1);
        check_hold(8'h5a, 8'h33, 1'b1, 1'b0);

        // Back-to-back: each op is accepted in the previous op's DONE cycle.
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            op(ra, rb, rc, rs, (i % 5) == 2);
        end
        check_hold(ra, rb, rc, rs);

        // Reset two cycles into an operation aborts it.
        bus.start = 1'b1;
        bus.a     = 8'hff;
        bus.b     = 8'hff;
        bus.cin   = 1'b1;
        bus.sub   = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_s", 32'(bus.s), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus.done), 32'h0);
        end
        op(8'hc4, 8'h4d, 1'b1, 1'b1, 1'b0);
        check_hold(8'hc4, 8'h4d, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
